// File: rtl/seq_tx_fsm_if.sv
// Handshake/bus bundle between a pattern controller (master) and seq_tx_fsm (slave).
interface seq_tx_fsm_if #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned REP_W = 4
) ();
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [REP_W-1:0] reps;
    logic             x;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pattern, len, reps,
        input  x, valid, busy, done
    );

    modport slave (
        input  start, abort, pattern, len, reps,
        output x, valid, busy, done
    );
endinterface

// File: rtl/seq_tx_fsm.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeated reps times.
// Optional SEQ_TX_PARITY_EN appends an even-parity bit after every repetition.
module seq_tx_fsm #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned REP_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    seq_tx_fsm_if.slave bus
);

`ifdef SEQ_TX_PARITY_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PAR, ST_DONE} state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;
`endif

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] bit_idx_q, bit_idx_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             x_q, x_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [LEN_W-1:0] len_eff;
    logic [REP_W-1:0] reps_eff;
    logic [PAT_W-1:0] in_sh;
    logic [PAT_W-1:0] next_sh;
    logic [PAT_W-1:0] reload_sh;
    logic             rep_end;

    // Out-of-range length/repeat requests are clamped at latch time
    assign len_eff  = (bus.len == '0 || bus.len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.len;
    assign reps_eff = (bus.reps == '0) ? REP_W'(1) : bus.reps;

    // Shifters select the bit to present after the coming edge
    assign in_sh     = bus.pattern >> (len_eff - LEN_W'(1));
    assign next_sh   = pat_q >> (bit_idx_q - LEN_W'(1));
    assign reload_sh = pat_q >> (len_q - LEN_W'(1));

`ifdef SEQ_TX_PARITY_EN
    logic [PAT_W-1:0] par_mask;
    logic             par_bit;
    assign par_mask = ~({PAT_W{1'b1}} << len_q);
    assign par_bit  = ^(pat_q & par_mask);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            bit_idx_q <= '0;
            rep_cnt_q <= '0;
            x_q       <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            bit_idx_q <= bit_idx_d;
            rep_cnt_q <= rep_cnt_d;
            x_q       <= x_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Outputs are computed for the state being entered, so they register with it
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        bit_idx_d = bit_idx_q;
        rep_cnt_d = rep_cnt_q;
        x_d       = 1'b0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        rep_end   = 1'b0;

        if (bus.abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_d   = ST_SHIFT;
                        pat_d     = bus.pattern;
                        len_d     = len_eff;
                        bit_idx_d = len_eff - LEN_W'(1);
                        rep_cnt_d = reps_eff - REP_W'(1);
                        x_d       = in_sh[0];
                        valid_d   = 1'b1;
                        busy_d    = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (bit_idx_q != '0) begin
                        bit_idx_d = bit_idx_q - LEN_W'(1);
                        x_d       = next_sh[0];
                        valid_d   = 1'b1;
                        busy_d    = 1'b1;
                    end else begin
`ifdef SEQ_TX_PARITY_EN
                        state_d = ST_PAR;
                        x_d     = par_bit;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
`else
                        rep_end = 1'b1;
`endif
                    end
                end
`ifdef SEQ_TX_PARITY_EN
                ST_PAR: rep_end = 1'b1;
`endif
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase

            // End of a repetition: reload contiguously or finish
            if (rep_end) begin
                busy_d = 1'b1;
                if (rep_cnt_q != '0) begin
                    state_d   = ST_SHIFT;
                    rep_cnt_d = rep_cnt_q - REP_W'(1);
                    bit_idx_d = len_q - LEN_W'(1);
                    x_d       = reload_sh[0];
                    valid_d   = 1'b1;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    assign bus.x     = x_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule
